upe_abs_arb: RTL

- Round-robin arbiter and sequencer that shares one combinational 32-bit absolute-value unit (upe_abs32s) between NREQ requesters.
- Accepts operands over per-requester valid/ready handshakes and drives the shared unit's input.
- Captures the unit's output into a single-entry result register, tagged with the requester ID and an overflow flag.
- Sits between UPE operand sources and the downstream uncertainty-propagation stage.

---
 rtl/upe_abs_arb.sv | 102 ++++++++++
 1 files changed

// File: rtl/upe_abs_arb.sv
// Purpose : round-robin arbiter sharing one combinational abs unit between NREQ operand sources.
// Latency : one cycle; a result is visible on res_* the cycle after its operand is accepted.
// Backpr. : single-entry result register; req_ready drops to zero while FULL and res_ready is low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_data holds requester i at [i*WIDTH +: WIDTH]
//   abs_in/abs_out        operand to / result from the shared abs unit
//   res_valid/res_ready   result handshake; res_data, res_id, res_ovf carry the registered result
module upe_abs_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      abs_in,
  input  logic [WIDTH-1:0]      abs_out,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_ovf,
  input  logic                  res_ready
);

  localparam logic [0:0]       ST_EMPTY = 1'b0;
  localparam logic [0:0]       ST_FULL  = 1'b1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDW-1:0]   LAST_RST = IDW'(NREQ-1);

  logic [0:0]       state;
  logic [IDW-1:0]   last;
  logic [WIDTH-1:0] hold_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   idx;
  logic             win_found;
  logic [WIDTH-1:0] win_data;
  logic             can_accept;
  logic             xfer;

  assign res_valid  = (state == ST_FULL);
  // A FULL register that is being drained this cycle can take a new result on the same edge.
  assign can_accept = (state == ST_EMPTY) | (res_valid & res_ready);

  // Search from last+1 upward; NREQ is a power of two, so IDW-bit wrap is the modulo.
  // k == NREQ wraps back to last itself, so a lone requester that just won can win again.
  always_comb begin
    grant     = '0;
    win_id    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + k[IDW-1:0];
      if (!win_found && req_valid[idx]) begin
        win_found   = 1'b1;
        win_id      = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  // grant is one-hot, so an OR-mux selects the winner's operand.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win_data = win_data | req_data[i*WIDTH +: WIDTH];
    end
  end

  assign req_ready = grant & {NREQ{can_accept}};
  assign xfer      = win_found & can_accept;
  // Keep the abs unit input steady when nobody is requesting.
  assign abs_in    = win_found ? win_data : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      last     <= LAST_RST;
      hold_q   <= '0;
      res_data <= '0;
      res_id   <= '0;
      res_ovf  <= 1'b0;
    end else begin
      if (win_found) hold_q <= win_data;
      if (xfer) begin
        res_data <= abs_out;
        res_id   <= win_id;
        res_ovf  <= (win_data == MOST_NEG);
        last     <= win_id;
        state    <= ST_FULL;
      end else if ((state == ST_FULL) && res_ready) begin
        state    <= ST_EMPTY;
      end
    end
  end

endmodule
